// File: rtl/jtframe_neptuno_joy_if.sv
// NeptUNO DB9 joystick shift-register pins (74HC165 chain plus Mega Drive select line).
// The master side is the scanner; the slave side is the shift-register chain.
interface jtframe_neptuno_joy_if;
  logic JOY_DATA;
  logic JOY_CLK;
  logic JOY_LOAD;
  logic JOY_SELECT;

  modport master (input JOY_DATA, output JOY_CLK, output JOY_LOAD, output JOY_SELECT);
  modport slave  (output JOY_DATA, input JOY_CLK, input JOY_LOAD, input JOY_SELECT);
endinterface

// File: rtl/jtframe_neptuno_joy.sv
// Continuous two-phase DB9 joystick scanner for the NeptUNO board.
// Reads the 16-bit 74HC165 chain with SELECT high and then low, and decodes Atari sticks and MD 3-button pads.
module jtframe_neptuno_joy #(
  parameter int unsigned CLKDIV = 16,
  parameter int unsigned SETTLE = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  jtframe_neptuno_joy_if.master       pins,
  output logic [7:0]                  joy1,
  output logic [7:0]                  joy2,
  output logic                        md1,
  output logic                        md2,
  output logic                        scan_done
);

  localparam int unsigned CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int unsigned SW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {ST_SETTLE, ST_LOAD, ST_SHIFT, ST_UPDATE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] scnt;
  logic [3:0]    bitn;
  logic          half;
  logic          phase_lo;
  logic [15:0]   sr;
  logic [15:0]   hi_raw;
  logic          tick;
  logic [15:0]   sr_next;

  assign tick    = (cnt == CW'(CLKDIV - 1));
  assign sr_next = {sr[14:0], pins.JOY_DATA};

  // Decode one port: {md, start, A, C, B, right, left, down, up}
  function automatic logic [8:0] decode(input logic [7:0] hi, input logic [7:0] lo);
    logic md;
    md = ~lo[3] & ~lo[2];
    return {md, (md ? lo[5] : 1'b1), (md ? lo[4] : 1'b1), hi[5], hi[4], hi[3:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_SETTLE;
      cnt             <= '0;
      scnt            <= '0;
      bitn            <= '0;
      half            <= 1'b0;
      phase_lo        <= 1'b0;
      sr              <= '1;
      hi_raw          <= '1;
      joy1            <= 8'hFF;
      joy2            <= 8'hFF;
      md1             <= 1'b0;
      md2             <= 1'b0;
      scan_done       <= 1'b0;
      pins.JOY_CLK    <= 1'b0;
      pins.JOY_LOAD   <= 1'b1;
      pins.JOY_SELECT <= 1'b1;
    end else begin
      scan_done <= 1'b0;
      // The tick counter pauses during the single-cycle UPDATE state
      if (state != ST_UPDATE) cnt <= tick ? '0 : cnt + CW'(1);
      case (state)
        ST_SETTLE: if (tick) begin
          pins.JOY_CLK <= 1'b0;
          if (scnt == SW'(SETTLE - 1)) begin
            scnt          <= '0;
            pins.JOY_LOAD <= 1'b0;
            state         <= ST_LOAD;
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        ST_LOAD: if (tick) begin
          pins.JOY_LOAD <= 1'b1;
          bitn          <= '0;
          half          <= 1'b0;
          state         <= ST_SHIFT;
        end
        ST_SHIFT: if (tick) begin
          if (!half) begin
            pins.JOY_CLK <= 1'b0;
            half         <= 1'b1;
          end else begin
            // Sample the current serial bit, then clock the chain to the next one
            half         <= 1'b0;
            pins.JOY_CLK <= 1'b1;
            sr           <= sr_next;
            bitn         <= bitn + 4'd1;
            if (bitn == 4'd15) begin
              if (phase_lo) begin
                state <= ST_UPDATE;
              end else begin
                hi_raw          <= sr_next;
                phase_lo        <= 1'b1;
                pins.JOY_SELECT <= 1'b0;
                state           <= ST_SETTLE;
              end
            end
          end
        end
        ST_UPDATE: begin
          {md1, joy1}     <= decode(hi_raw[15:8], sr[15:8]);
          {md2, joy2}     <= decode(hi_raw[7:0], sr[7:0]);
          scan_done       <= 1'b1;
          phase_lo        <= 1'b0;
          pins.JOY_SELECT <= 1'b1;
          state           <= ST_SETTLE;
        end
        default: state <= ST_SETTLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_neptuno_joy.sv
// Directed bench for jtframe_neptuno_joy: a behavioural 74HC165 chain feeds per-phase vectors.
// A second instance with CLKDIV=2 and SETTLE=1 checks the scan period.
module tb_jtframe_neptuno_joy;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtframe_neptuno_joy_if jif ();
  jtframe_neptuno_joy_if fif ();

  logic [7:0] joy1, joy2, joy1_f, joy2_f;
  logic       md1, md2, scan_done, md1_f, md2_f, scan_done_f;

  jtframe_neptuno_joy #(.CLKDIV(16), .SETTLE(8)) dut (
    .clk(clk), .rst(rst), .pins(jif.master),
    .joy1(joy1), .joy2(joy2), .md1(md1), .md2(md2), .scan_done(scan_done)
  );

  jtframe_neptuno_joy #(.CLKDIV(2), .SETTLE(1)) dut_fast (
    .clk(clk), .rst(rst), .pins(fif.master),
    .joy1(joy1_f), .joy2(joy2_f), .md1(md1_f), .md2(md2_f), .scan_done(scan_done_f)
  );

  // Shift-register model: parallel load while LOAD low, shift on JOY_CLK rise
  logic [15:0] hi_vec = 16'hFFFF;
  logic [15:0] lo_vec = 16'hFFFF;
  logic [15:0] sr_m   = 16'hFFFF;
  logic        clk_q  = 1'b0;

  always @(posedge clk) begin
    if (!jif.JOY_LOAD) sr_m <= jif.JOY_SELECT ? hi_vec : lo_vec;
    else if (jif.JOY_CLK && !clk_q) sr_m <= {sr_m[14:0], 1'b1};
    clk_q <= jif.JOY_CLK;
  end
  assign jif.JOY_DATA = sr_m[15];
  assign fif.JOY_DATA = 1'b1;

  int checks   = 0;
  int failures = 0;

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!scan_done && n < 3000);
    if (!scan_done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got=no scan_done exp=scan_done within 3000 clk", tag);
    end
  endtask

  task automatic apply(input logic [15:0] h, input logic [15:0] l, input string tag);
    wait_done(tag);
    hi_vec = h;
    lo_vec = l;
    wait_done(tag);
  endtask

  task automatic check_out(input string tag, input logic [17:0] exp);
    // local helper is not used; comparisons are inline in each test
  endtask

  task automatic test_reset;
    logic [22:0] got;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    got = {jif.JOY_LOAD, jif.JOY_CLK, jif.JOY_SELECT, joy1, joy2, md1, md2, scan_done};
    checks++;
    if (got !== {1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", got, {1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0});
    end
    rst = 1'b0;
  endtask

  task automatic test_idle;
    logic [17:0] got;
    apply(16'hFFFF, 16'hFFFF, "idle");
    got = {joy1, joy2, md1, md2};
    checks++;
    if (got !== {8'hFF, 8'hFF, 2'b00}) begin
      failures++;
      $display("FAIL idle_all_ones got=%h exp=%h", got, {8'hFF, 8'hFF, 2'b00});
    end
  endtask

  task automatic test_atari;
    logic [17:0] got;
    // Port1 up + fire B, same in both phases
    apply({8'hEE, 8'hFF}, {8'hEE, 8'hFF}, "atari");
    got = {joy1, joy2, md1, md2};
    checks++;
    if (got !== {8'hEE, 8'hFF, 2'b00}) begin
      failures++;
      $display("FAIL atari_up_fire got=%h exp=%h", got, {8'hEE, 8'hFF, 2'b00});
    end
    // Only left low in LO phase is not an MD pad, so lo[4]=0 must not read as A
    apply({8'hFF, 8'hFF}, {8'hEB, 8'hFF}, "atari_left");
    got = {joy1, joy2, md1, md2};
    checks++;
    if (got !== {8'hFF, 8'hFF, 2'b00}) begin
      failures++;
      $display("FAIL atari_no_md got=%h exp=%h", got, {8'hFF, 8'hFF, 2'b00});
    end
  endtask

  task automatic test_md_pad;
    logic [17:0] got;
    apply({8'hFF, 8'hFF}, {8'hFF, 8'hE3}, "md_a");
    got = {joy1, joy2, md1, md2};
    checks++;
    if (got !== {8'hFF, 8'hBF, 2'b01}) begin
      failures++;
      $display("FAIL md_a_port2 got=%h exp=%h", got, {8'hFF, 8'hBF, 2'b01});
    end
    apply({8'hFF, 8'hFF}, {8'hFF, 8'h03}, "md_start");
    got = {joy1, joy2, md1, md2};
    checks++;
    if (got !== {8'hFF, 8'h3F, 2'b01}) begin
      failures++;
      $display("FAIL md_start_a_port2 got=%h exp=%h", got, {8'hFF, 8'h3F, 2'b01});
    end
    // Port1 MD pad with C, B, left, up pressed; raw bits 7:6 are ignored
    apply({8'h0A, 8'hFF}, {8'h33, 8'hFF}, "md_port1");
    got = {joy1, joy2, md1, md2};
    checks++;
    if (got !== {8'hCA, 8'hFF, 2'b10}) begin
      failures++;
      $display("FAIL md_bc_port1 got=%h exp=%h", got, {8'hCA, 8'hFF, 2'b10});
    end
  endtask

  task automatic test_shift_order;
    logic [17:0] got;
    apply({8'h7F, 8'hFF}, 16'hFFFF, "s15");
    got = {joy1, joy2, md1, md2};
    checks++;
    if (got !== {8'hFF, 8'hFF, 2'b00}) begin
      failures++;
      $display("FAIL order_s15 got=%h exp=%h", got, {8'hFF, 8'hFF, 2'b00});
    end
    apply({8'hFF, 8'hFE}, 16'hFFFF, "s0");
    got = {joy1, joy2, md1, md2};
    checks++;
    if (got !== {8'hFF, 8'hFE, 2'b00}) begin
      failures++;
      $display("FAIL order_s0 got=%h exp=%h", got, {8'hFF, 8'hFE, 2'b00});
    end
    apply({8'hFE, 8'hFF}, 16'hFFFF, "s8");
    got = {joy1, joy2, md1, md2};
    checks++;
    if (got !== {8'hFE, 8'hFF, 2'b00}) begin
      failures++;
      $display("FAIL order_s8 got=%h exp=%h", got, {8'hFE, 8'hFF, 2'b00});
    end
  endtask

  task automatic test_reset_mid_shift;
    logic [22:0] got;
    int n;
    wait_done("midrst");
    // 900 clk after UPDATE lands in the middle of the LO-phase SHIFT
    repeat (900) @(negedge clk);
    checks++;
    if (jif.JOY_SELECT !== 1'b0 || jif.JOY_LOAD !== 1'b1) begin
      failures++;
      $display("FAIL midrst_precond got=sel%b load%b exp=sel0 load1", jif.JOY_SELECT, jif.JOY_LOAD);
    end
    rst = 1'b1;
    @(negedge clk);
    got = {jif.JOY_LOAD, jif.JOY_CLK, jif.JOY_SELECT, joy1, joy2, md1, md2, scan_done};
    checks++;
    if (got !== {1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midrst_state got=%h exp=%h", got, {1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!scan_done && n < 3000);
    checks++;
    if (n != 1313) begin
      failures++;
      $display("FAIL midrst_first_done got=%0d exp=1313", n);
    end
    checks++;
    if (joy1 !== 8'hFE) begin
      failures++;
      $display("FAIL midrst_rescan_joy1 got=%h exp=fe", joy1);
    end
  endtask

  task automatic test_pin_timing;
    int n, rises_hi, rises_lo, load_len, load_min, load_max, load_cnt, last_sel, gap_min, overlap;
    logic prev_clk, prev_sel, prev_load;
    wait_done("pins");
    rises_hi = 0; rises_lo = 0; load_len = 0; load_min = 9999; load_max = 0;
    load_cnt = 0; last_sel = 0; gap_min = 9999; overlap = 0;
    prev_clk = jif.JOY_CLK; prev_sel = jif.JOY_SELECT; prev_load = jif.JOY_LOAD;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (jif.JOY_CLK && !prev_clk) begin
        if (prev_sel) rises_hi++;
        else rises_lo++;
      end
      if (jif.JOY_SELECT != prev_sel) last_sel = n;
      if (!jif.JOY_LOAD) begin
        load_len++;
        if (prev_load) begin
          load_cnt++;
          if (n - last_sel < gap_min) gap_min = n - last_sel;
        end
        if (jif.JOY_CLK) overlap++;
      end else if (!prev_load) begin
        if (load_len < load_min) load_min = load_len;
        if (load_len > load_max) load_max = load_len;
        load_len = 0;
      end
      prev_clk = jif.JOY_CLK; prev_sel = jif.JOY_SELECT; prev_load = jif.JOY_LOAD;
    end while (!scan_done && n < 3000);
    checks++;
    if (n != 1313) begin failures++; $display("FAIL frame_len got=%0d exp=1313", n); end
    checks++;
    if (rises_hi != 16 || rises_lo != 16) begin
      failures++;
      $display("FAIL clk_rises got=hi%0d lo%0d exp=hi16 lo16", rises_hi, rises_lo);
    end
    checks++;
    if (load_cnt != 2 || load_min != 16 || load_max != 16) begin
      failures++;
      $display("FAIL load_width got=cnt%0d min%0d max%0d exp=cnt2 min16 max16", load_cnt, load_min, load_max);
    end
    checks++;
    if (gap_min < 128) begin failures++; $display("FAIL select_to_load got=%0d exp>=128", gap_min); end
    checks++;
    if (overlap != 0) begin failures++; $display("FAIL load_clk_overlap got=%0d exp=0", overlap); end
  endtask

  task automatic test_fast_period;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!scan_done_f && n < 500);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!scan_done_f && n < 500);
    checks++;
    if (n != 137) begin failures++; $display("FAIL fast_period got=%0d exp=137", n); end
    checks++;
    if ({joy1_f, joy2_f, md1_f, md2_f} !== {8'hFF, 8'hFF, 2'b00}) begin
      failures++;
      $display("FAIL fast_idle got=%h exp=%h", {joy1_f, joy2_f, md1_f, md2_f}, {8'hFF, 8'hFF, 2'b00});
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_atari();
    test_md_pad();
    test_shift_order();
    test_reset_mid_shift();
    test_pin_timing();
    test_fast_period();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
